// File: rtl/seg_counter_mux_if.sv
// Switch-side controls and display-side results of the multiplexed BCD counter.
// master drives the controls; slave is the counter/display block.
interface seg_counter_mux_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    en;
    logic                    up_dn;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    wrap;

    modport master (
        output en, up_dn, load, load_val, blank_lz,
        input  seg, dig_sel, count, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val, blank_lz,
        output seg, dig_sel, count, wrap
    );
endinterface

// File: rtl/seg_counter_mux.sv
// N-digit BCD up/down counter with prescaler tick, synchronous load and wrap pulse,
// driving a time-multiplexed 7-segment bus with optional leading-zero blanking.

// One BCD digit of the carry/borrow chain.
module seg_counter_mux_digit (
    input  logic [3:0] d,
    input  logic       cin,
    input  logic       up,
    output logic [3:0] nxt,
    output logic       cout
);
    always_comb begin
        nxt  = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                cout = (d >= 4'd9);
                nxt  = cout ? 4'd0 : d + 4'd1;
            end else begin
                cout = (d == 4'd0);
                nxt  = cout ? 4'd9 : d - 4'd1;
            end
        end
    end
endmodule

module seg_counter_mux #(
    parameter logic [23:0] DIV_COUNT  = 24'd10_000_000,
    parameter int          NUM_DIGITS = 2,
    parameter logic [15:0] SCAN_DIV   = 16'd1000
) (
    input  logic              clk,
    input  logic              rst,
    seg_counter_mux_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [23:0]                 pre;
    logic                        tick;
    logic [NUM_DIGITS-1:0][3:0]  cnt, cnt_nxt, ld_clean;
    logic [NUM_DIGITS:0]         carry;
    logic [NUM_DIGITS-1:0]       hi_zero;
    logic [15:0]                 scan;
    logic [IDX_W-1:0]            idx;
    logic [6:0]                  seg_r, seg_d;
    logic [NUM_DIGITS-1:0]       sel_r;
    logic                        wrap_r;
    logic [3:0]                  cur;
    logic                        blank;

    assign tick     = bus.en && (pre == DIV_COUNT - 24'd1);
    assign carry[0] = 1'b1;

    // Carry out of the top digit means every digit rolled over: that is the wrap.
    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
            seg_counter_mux_digit u_dig (
                .d    (cnt[i]),
                .cin  (carry[i]),
                .up   (bus.up_dn),
                .nxt  (cnt_nxt[i]),
                .cout (carry[i+1])
            );
            assign ld_clean[i] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
            if (i == NUM_DIGITS - 1) begin : g_top
                assign hi_zero[i] = (cnt[i] == 4'd0);
            end else begin : g_low
                assign hi_zero[i] = (cnt[i] == 4'd0) && hi_zero[i+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            cnt    <= '0;
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            if (bus.load) begin
                cnt <= ld_clean;
                pre <= '0;
            end else begin
                if (tick) begin
                    cnt    <= cnt_nxt;
                    wrap_r <= carry[NUM_DIGITS];
                end
                if (bus.en) pre <= tick ? 24'd0 : pre + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan <= '0;
            idx  <= '0;
        end else if (scan == SCAN_DIV - 16'd1) begin
            scan <= '0;
            idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            scan <= scan + 16'd1;
        end
    end

    always_comb begin
        cur   = cnt[idx];
        blank = bus.blank_lz && (idx != '0) && hi_zero[idx];
        case (cur)
            4'd0:    seg_d = 7'h3F;
            4'd1:    seg_d = 7'h06;
            4'd2:    seg_d = 7'h5B;
            4'd3:    seg_d = 7'h4F;
            4'd4:    seg_d = 7'h66;
            4'd5:    seg_d = 7'h6D;
            4'd6:    seg_d = 7'h7D;
            4'd7:    seg_d = 7'h07;
            4'd8:    seg_d = 7'h7F;
            4'd9:    seg_d = 7'h6F;
            default: seg_d = 7'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= '0;
            sel_r <= '0;
        end else begin
            seg_r <= blank ? 7'h00 : seg_d;
            sel_r <= NUM_DIGITS'(1) << idx;
        end
    end

    assign bus.seg     = seg_r;
    assign bus.dig_sel = sel_r;
    assign bus.count   = cnt;
    assign bus.wrap    = wrap_r;
endmodule

// File: tb/tb_seg_counter_mux.sv
// Scoreboarded bench: a decimal-integer model predicts every post-edge output,
// a monitor process compares the DUT against the queued predictions.
module tb_seg_counter_mux;
    localparam int DIV = 4;
    localparam int ND  = 2;
    localparam int SD  = 2;

    typedef struct {
        logic [7:0] count;
        logic [6:0] seg;
        logic [1:0] sel;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_counter_mux_if #(.NUM_DIGITS(ND)) bus ();

    seg_counter_mux #(
        .DIV_COUNT  (24'd4),
        .NUM_DIGITS (ND),
        .SCAN_DIV   (16'd2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Model state: count is a plain decimal number 0..99.
    int m_cnt, m_pre, m_scan, m_idx;
    int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int clean_load(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 9) ? 0 : int'(v[7:4]);
        lo = (v[3:0] > 9) ? 0 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    // Predict the outputs seen after the coming edge, given the inputs now on the bus.
    task automatic cycle();
        exp_t e;
        int   p10, dgt;
        bit   tck;
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_scan = 0; m_idx = 0;
            e.seg = 7'h00; e.sel = 2'b00; e.wrap = 1'b0;
        end else begin
            p10   = (m_idx == 0) ? 1 : 10;
            dgt   = (m_cnt / p10) % 10;
            e.sel = 2'(1 << m_idx);
            e.seg = (bus.blank_lz && m_idx > 0 && (m_cnt / p10) == 0) ? 7'h00 : 7'(seg_tab[dgt]);
            e.wrap = 1'b0;
            tck = bus.en && (m_pre == DIV - 1);
            if (bus.load) begin
                m_cnt = clean_load(bus.load_val);
                m_pre = 0;
            end else begin
                if (tck) begin
                    if (bus.up_dn) begin
                        e.wrap = (m_cnt == 99);
                        m_cnt  = (m_cnt + 1) % 100;
                    end else begin
                        e.wrap = (m_cnt == 0);
                        m_cnt  = (m_cnt + 99) % 100;
                    end
                end
                if (bus.en) m_pre = (m_pre + 1) % DIV;
            end
            if (m_scan == SD - 1) m_idx = (m_idx + 1) % ND;
            m_scan = (m_scan + 1) % SD;
        end
        e.count = 8'(bcd(m_cnt));
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_once(input logic [7:0] v);
        bus.load = 1'b1; bus.load_val = v;
        cycle();
        bus.load = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("count", int'(bus.count), int'(e.count));
            check("seg", int'(bus.seg), int'(e.seg));
            check("dig_sel", int'(bus.dig_sel), int'(e.sel));
            check("wrap", int'(bus.wrap), int'(e.wrap));
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        bus.en = 1'b0; bus.up_dn = 1'b1; bus.load = 1'b0;
        bus.load_val = 8'h00; bus.blank_lz = 1'b0;
        m_cnt = 0; m_pre = 0; m_scan = 0; m_idx = 0;
        #1;
        check("rst_count", int'(bus.count), 0);
        check("rst_seg", int'(bus.seg), 0);
        check("rst_sel", int'(bus.dig_sel), 0);
        check("rst_wrap", int'(bus.wrap), 0);
        @(negedge clk);
        run(3);
        rst = 1'b0;

        bus.en = 1'b1; bus.up_dn = 1'b1;
        run(44);
        load_once(8'h99);
        run(6);

        bus.up_dn = 1'b0;
        load_once(8'h00);
        run(10);
        load_once(8'h10);
        run(5);

        bus.en = 1'b0;
        load_once(8'h4F);
        run(3);

        bus.en = 1'b1; bus.up_dn = 1'b1;
        guard = 0;
        while (m_pre != DIV - 1 && guard < 10) begin
            cycle();
            guard++;
        end
        check("tick_align", m_pre, DIV - 1);
        load_once(8'h25);
        run(8);

        load_once(8'h07);
        bus.en = 1'b0; bus.blank_lz = 1'b1;
        run(8);
        bus.blank_lz = 1'b0;
        run(4);

        bus.en = 1'b1;
        run(2);
        bus.en = 1'b0;
        run(10);
        bus.en = 1'b1;
        run(6);

        // Reset asserted between edges must clear outputs without waiting for clk.
        #2 rst = 1'b1;
        #1;
        check("async_count", int'(bus.count), 0);
        check("async_seg", int'(bus.seg), 0);
        check("async_sel", int'(bus.dig_sel), 0);
        check("async_wrap", int'(bus.wrap), 0);
        cycle();
        rst = 1'b0;
        run(10);

        for (int i = 0; i < 1500; i++) begin
            bus.en       = ($urandom_range(0, 99) < 85);
            bus.load     = ($urandom_range(0, 99) < 5);
            bus.load_val = 8'($urandom);
            if ($urandom_range(0, 19) == 0) bus.up_dn = ~bus.up_dn;
            if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 199) == 0) begin
                bus.load = 1'b1;
                bus.load_val = bus.up_dn ? 8'h99 : 8'h00;
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0; bus.load = 1'b0;
        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
